// File: rtl/hs_fifo_if.sv
// Handshake and status bundle for hs_fifo: upstream req/ack, downstream req/ack, counters.
// master = the FIFO side, slave = the surrounding graph/consumer side.
interface hs_fifo_if #(
  parameter int data_width = 32,
  parameter int addr_width = 2
);
  logic                  up_req;
  logic                  up_ack;
  logic [data_width-1:0] up_din;
  logic                  dn_req;
  logic                  dn_ack;
  logic [data_width-1:0] dn_dout;
  logic [addr_width:0]   occupancy;
  logic [31:0]           count_in;
  logic [31:0]           count_out;
  logic                  err;
  logic [addr_width:0]   max_occ;
  logic [31:0]           stall_cycles;

  modport master (
    output up_req,
    input  up_ack, up_din,
    input  dn_req,
    output dn_ack, dn_dout,
    output occupancy, count_in, count_out, err, max_occ, stall_cycles
  );

  modport slave (
    input  up_req,
    output up_ack, up_din,
    output dn_req,
    input  dn_ack, dn_dout,
    input  occupancy, count_in, count_out, err, max_occ, stall_cycles
  );
endinterface

// File: rtl/hs_fifo.sv
// Elastic req/ack buffer between a graph output port and its consumer.
// Define HS_FIFO_STATS_EN to build the max_occ / stall_cycles statistics.
module hs_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int addr_width = 2
) (
  input  logic     clk,
  input  logic     rst,
  hs_fifo_if.master bus
);
  localparam logic [addr_width:0] DEPTH_C = (addr_width+1)'(depth);

  logic [data_width-1:0] r_mem [depth];
  logic [addr_width-1:0] r_wr_ptr, r_rd_ptr;
  logic [addr_width:0]   r_occ;
  logic                  r_up_req, r_dn_ack, r_err;
  logic [data_width-1:0] r_dn_dout;
  logic [31:0]           r_count_in, r_count_out;

  logic                  w_full, w_wr, w_rd, w_ovf;
  logic [addr_width:0]   w_occ_nxt;

  // All decisions use the pre-edge occupancy, so a fresh write is not readable this edge.
  assign w_full = (r_occ == DEPTH_C);
  assign w_wr   = bus.up_ack && !w_full;
  assign w_ovf  = bus.up_ack &&  w_full;
  assign w_rd   = bus.dn_req && !r_dn_ack && (r_occ != '0);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr, w_rd})
      2'b10:   w_occ_nxt = r_occ + (addr_width+1)'(1);
      2'b01:   w_occ_nxt = r_occ - (addr_width+1)'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr && !rst) r_mem[r_wr_ptr] <= bus.up_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_up_req    <= 1'b0;
      r_dn_ack    <= 1'b0;
      r_dn_dout   <= '0;
      r_count_in  <= '0;
      r_count_out <= '0;
      r_err       <= 1'b0;
    end else begin
      // Ack wins over re-raising the request in the same edge.
      if (w_wr) begin
        r_wr_ptr   <= r_wr_ptr + addr_width'(1);
        r_count_in <= r_count_in + 32'd1;
        r_up_req   <= 1'b0;
      end else if (!r_up_req && !w_full) begin
        r_up_req <= 1'b1;
      end
      if (w_ovf) r_err <= 1'b1;
      r_dn_ack <= w_rd;
      if (w_rd) begin
        r_dn_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + addr_width'(1);
        r_count_out <= r_count_out + 32'd1;
      end
      r_occ <= w_occ_nxt;
    end
  end

  assign bus.up_req    = r_up_req;
  assign bus.dn_ack    = r_dn_ack;
  assign bus.dn_dout   = r_dn_dout;
  assign bus.occupancy = r_occ;
  assign bus.count_in  = r_count_in;
  assign bus.count_out = r_count_out;
  assign bus.err       = r_err;

`ifdef HS_FIFO_STATS_EN
  logic [addr_width:0] r_max_occ;
  logic [31:0]         r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_occ <= '0;
      r_stall   <= '0;
    end else begin
      if (w_occ_nxt > r_max_occ) r_max_occ <= w_occ_nxt;
      if (bus.dn_req && !r_dn_ack && (r_occ == '0)) r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.max_occ      = r_max_occ;
  assign bus.stall_cycles = r_stall;
`else
  assign bus.max_occ      = '0;
  assign bus.stall_cycles = '0;
`endif
endmodule

// File: doc/hs_fifo.md
# hs_fifo

Elastic req/ack buffer inserted between the `out` operator port of a generated `arf` graph and its `consumer`. On its upstream side it acts as the requester: it raises `up_req` and captures `up_din` when the upstream stage returns `up_ack`. On its downstream side it acts as a responder, using the same single-cycle ack-pulse protocol as `producer`. The buffer decouples consumer stalls from the graph so that throughput measurements reflect graph capacity, not consumer jitter.

## Interface
Parameters:
- `data_width`, 32, payload width.
- `depth`, 4, number of entries. Must be a power of 2, minimum 2.
- `addr_width`, 2, equals log2(`depth`).

Ports:
- `clk`  in  1  clock. Reset `rst` is synchronous and active-high; clock is `clk`.
- `rst`  in  1  synchronous active-high reset.
- `up_req`  out  1  request to the upstream stage; connects to the upstream `req_r`/`dout_req`.
- `up_ack`  in  1  upstream ack pulse. `up_din` is valid while it is high.
- `up_din`  in  `data_width`  upstream data.
- `dn_req`  in  1  request from the consumer.
- `dn_ack`  out  1  ack pulse to the consumer.
- `dn_dout`  out  `data_width`  data to the consumer, valid while `dn_ack` is high.
- `occupancy`  out  `addr_width`+1  number of stored entries.
- `count_in`, `count_out`  out  32 each  totals of accepted and delivered items.
- `err`  out  1  sticky protocol-violation flag.
- `max_occ`  out  `addr_width`+1  occupancy high-water mark (see Configuration).
- `stall_cycles`  out  32  cycles with `dn_req`=1 and the FIFO empty (see Configuration).

## Operation
- Storage: circular buffer `mem[depth]` with write pointer `wr_ptr` and read pointer `rd_ptr`. Both pointers are `addr_width` bits and wrap naturally. `occupancy` is a separate registered counter.
- Upstream side, evaluated each edge:
  - If `up_req`=0 and `occupancy`<`depth`, set `up_req`<=1.
  - If `up_ack`=1 and `occupancy`<`depth`: write `mem[wr_ptr]`<=`up_din`, increment `wr_ptr`, increment `count_in`, and set `up_req`<=0. The ack takes priority over the set rule in the same edge.
  - If `up_ack`=1 while `occupancy`=`depth`: drop the data, set `err`<=1, and leave pointers unchanged.
- Downstream side, evaluated each edge:
  - Default `dn_ack`<=0.
  - If `dn_req`=1, `dn_ack`=0 and `occupancy`>0: set `dn_ack`<=1 and `dn_dout`<=`mem[rd_ptr]`, increment `rd_ptr`, increment `count_out`.
- Occupancy update:
  - write only: +1.
  - read only: −1.
  - both in the same edge: unchanged.
  - All decisions use pre-edge `occupancy`. A write into an empty FIFO is therefore not readable in the same edge.
- `dn_dout` holds its last value between acks.
- Because `up_req` is only asserted when `occupancy`<`depth` and occupancy cannot grow while a request is outstanding, a well-behaved upstream never overflows the FIFO.

## Timing
- Reset values: `up_req`=0, `dn_ack`=0, `dn_dout`=0, `occupancy`=0, pointers=0, `count_in`=`count_out`=0, `err`=0, `max_occ`=0, `stall_cycles`=0.
- First `up_req` rises at the first edge after `rst` deasserts.
- Latency: data written at edge N can produce `dn_ack` at edge N+1 at the earliest. Fall-through latency is 1 cycle.
- Downstream peak rate is 1 item per 2 cycles (ack pulse, then a mandatory low cycle). Upstream peak is bounded by the upstream stage.
- Reset mid-operation discards all contents and any outstanding request. An `up_ack` sampled while `rst`=1 is ignored.

## Configuration
- `HS_FIFO_STATS_EN` defined:
  - `max_occ` tracks the maximum post-update `occupancy` seen since reset.
  - `stall_cycles` increments on every non-reset edge where `dn_req`=1, `dn_ack`=0 and `occupancy`=0.
- `HS_FIFO_STATS_EN` undefined: both ports are tied to constant 0 and no stats logic is built. All other behaviour is identical.

## Test plan
- Reset, then `producer`-style upstream with no downstream request. `up_req` asserts at edge 1. After 4 acks, `occupancy`=4 and `up_req` stays 0. `count_in`=4, `err`=0.
- Continue from the full state and raise `dn_req`=1. `dn_ack` pulses every 2nd cycle, delivering values 0,1,2,3 in order. `up_req` re-asserts one edge after the first read. `count_out` reaches 4.
- Push a single value 7 into an empty FIFO with `dn_req` held high. `up_ack` at edge N gives `dn_ack`=1 with `dn_dout`=7 at edge N+1. No `dn_ack` at edge N.
- Force `up_ack`=1 with `up_din`=0xDEAD while `occupancy`=4. `err` becomes 1 and stays 1. `occupancy` stays 4. The dropped value never appears on `dn_dout`.
- Assert `rst` for 1 cycle mid-stream with `occupancy`=3. All outputs return to their reset values. Items resume from the next `up_din`, and no stale data is delivered.
- With `HS_FIFO_STATS_EN` defined: hold `dn_req`=1 for 10 idle cycles with an empty FIFO, then fill it to 3. Expect `stall_cycles`=10 and `max_occ`=3. With the macro undefined, both read 0.
